// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, MDU state encoding and special-case result rules
package alu_pkg;
  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_AND   = 5'b00010;
  localparam logic [4:0] OP_OR    = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_ROL   = 5'b01100;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTHI  = 5'b10100;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MFHI  = 5'b10110;
  localparam logic [4:0] OP_MFLO  = 5'b10111;
  localparam logic [4:0] OP_FILL  = 5'b11111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} mdu_state_t;
  // Divide by zero does not trap: LO is filled with this bit (all ones), HI gets the dividend.
  localparam bit DIVZ_LO_BIT = 1'b1;
  // Signed MIN / -1: LO = MIN (the wrapped quotient), HI is filled with this bit (zero).
  localparam bit OVF_HI_BIT  = 1'b0;
  function automatic logic is_mul(input logic [4:0] op);
    return op == OP_MULT || op == OP_MULTU;
  endfunction
  function automatic logic is_div(input logic [4:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_signed_op(input logic [4:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction
endpackage

// File: rtl/mdu_core.sv
// mdu_core: iterative multiply/divide unit with HI/LO registers.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_op, i_a, i_b, i_start
// launch an op from IDLE; o_busy while iterating (incl. FIX), o_done one-cycle
// pulse after HI/LO update; o_hi/o_lo registers.
// Optional: ALU_MDU_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module mdu_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  mdu_state_t r_state, w_next;
  logic [SHW-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_wk, r_mc, w_mul_step, w_div_step, w_prod;
  logic [WIDTH-1:0] r_mp, r_a, r_hi, r_lo, w_am, w_bm, w_mp_rest, w_rem, w_quo, w_q, w_r, w_fix_hi, w_fix_lo;
  logic [WIDTH:0] w_trial;
  logic r_nq, r_nr, r_dz, r_ovf, r_is_div, r_done;
  logic w_sgn, w_aneg, w_bneg, w_launch_mul, w_launch_div, w_early;
  assign w_sgn        = is_signed_op(i_op);
  assign w_aneg       = w_sgn & i_a[WIDTH-1];
  assign w_bneg       = w_sgn & i_b[WIDTH-1];
  assign w_am         = w_aneg ? -i_a : i_a;
  assign w_bm         = w_bneg ? -i_b : i_b;
  assign w_launch_mul = i_start && r_state == S_IDLE && is_mul(i_op);
  assign w_launch_div = i_start && r_state == S_IDLE && is_div(i_op);
  assign w_mp_rest    = r_mp >> 1;
`ifdef ALU_MDU_EARLY_OUT_EN
  assign w_early = w_mp_rest == '0;
`else
  assign w_early = 1'b0;
`endif
  // Multiply: multiplicand shifts left against a right-shifting multiplier, so
  // the partial product is always correctly aligned and can stop early.
  assign w_mul_step = r_mp[0] ? r_wk + r_mc : r_wk;
  // Restoring division on {remainder, dividend/quotient}: quotient bits shift in at the bottom.
  assign w_rem      = r_wk[2*WIDTH-1:WIDTH];
  assign w_quo      = r_wk[WIDTH-1:0];
  assign w_trial    = {w_rem, w_quo[WIDTH-1]} - {1'b0, r_mc[WIDTH-1:0]};
  assign w_div_step = w_trial[WIDTH] ? r_wk << 1 : {w_trial[WIDTH-1:0], w_quo[WIDTH-2:0], 1'b1};
  assign w_prod     = r_nq ? -r_wk : r_wk;
  assign w_q        = r_nq ? -w_quo : w_quo;
  assign w_r        = r_nr ? -w_rem : w_rem;
  assign w_fix_hi   = r_is_div ? (r_dz ? r_a : r_ovf ? {WIDTH{OVF_HI_BIT}} : w_r) : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo   = r_is_div ? (r_dz ? {WIDTH{DIVZ_LO_BIT}} : r_ovf ? MIN : w_q) : w_prod[WIDTH-1:0];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_launch_mul ? S_MUL : w_launch_div ? S_DIV : S_IDLE;
      S_MUL:   w_next = (r_cnt == '0 || w_early) ? S_FIX : S_MUL;
      S_DIV:   w_next = r_cnt == '0 ? S_FIX : S_DIV;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    o_busy = r_state != S_IDLE;
    o_done = r_done;
    o_hi   = r_hi;
    o_lo   = r_lo;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_wk     <= '0;
      r_mc     <= '0;
      r_mp     <= '0;
      r_a      <= '0;
      r_nq     <= 1'b0;
      r_nr     <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= r_state == S_FIX;
      if (w_launch_mul || w_launch_div) begin
        r_cnt    <= SHW'(WIDTH-1);
        r_mc     <= {{WIDTH{1'b0}}, w_launch_mul ? w_am : w_bm};
        r_mp     <= w_bm;
        r_wk     <= w_launch_mul ? '0 : {{WIDTH{1'b0}}, w_am};
        r_nq     <= w_aneg ^ w_bneg;
        r_nr     <= w_aneg;
        r_a      <= i_a;
        r_is_div <= w_launch_div;
        r_dz     <= i_b == '0;
        r_ovf    <= w_sgn && i_a == MIN && i_b == '1;
      end else if (r_state == S_MUL) begin
        r_wk  <= w_mul_step;
        r_mc  <= r_mc << 1;
        r_mp  <= w_mp_rest;
        r_cnt <= r_cnt - SHW'(1);
      end else if (r_state == S_DIV) begin
        r_wk  <= w_div_step;
        r_cnt <= r_cnt - SHW'(1);
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_FIX) begin
      r_hi <= w_fix_hi;
      r_lo <= w_fix_lo;
    end else if (r_state == S_IDLE && i_start) begin
      if (i_op == OP_MTHI) r_hi <= i_a;
      if (i_op == OP_MTLO) r_lo <= i_a;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with combinational ops plus an iterative multiply/divide unit.
// Ports: i_clk, i_rst_n (async active-low); i_alu_op op code; i_a, i_b operands;
// i_shamt shift amount; i_start launches MDU/MTHI/MTLO; o_alu_result combinational
// result; o_busy, o_done MDU handshake; o_hi, o_lo HI/LO registers.
// Optional: ALU_MDU_EARLY_OUT_EN (see mdu_core) shortens multiplies by small operands.
module alu_mdu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_alu_result,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [2*WIDTH-1:0] w_rol2;
  logic [WIDTH-1:0] w_fill, w_sra;
  logic [WIDTH:0] w_zc;
  mdu_core #(.WIDTH(WIDTH)) u_mdu (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_op   (i_alu_op),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_start(i_start),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_hi   (o_hi),
    .o_lo   (o_lo)
  );
  // Rotate via a doubled word: the upper half after the shift is the rotation.
  assign w_rol2 = {i_a, i_a} << i_b[SHW-1:0];
  assign w_sra  = $signed(i_b) >>> i_shamt;
  // Fill: a zero bit is set while fewer than b zeros have been seen below it.
  always_comb begin
    w_fill = i_a;
    w_zc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_fill[i] = i_a[i] | (w_zc < {1'b0, i_b});
      w_zc      = w_zc + {{WIDTH{1'b0}}, ~i_a[i]};
    end
  end
  always_comb begin
    o_alu_result = i_a + i_b;
    case (i_alu_op)
      OP_SUB:  o_alu_result = i_a - i_b;
      OP_AND:  o_alu_result = i_a & i_b;
      OP_OR:   o_alu_result = i_a | i_b;
      OP_SLL:  o_alu_result = i_b << i_shamt;
      OP_SRL:  o_alu_result = i_b >> i_shamt;
      OP_SRA:  o_alu_result = w_sra;
      OP_SLT:  o_alu_result = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      OP_SLTU: o_alu_result = {{(WIDTH-1){1'b0}}, i_a < i_b};
      OP_ROL:  o_alu_result = w_rol2[2*WIDTH-1:WIDTH];
      OP_FILL: o_alu_result = w_fill;
      OP_MFHI: o_alu_result = o_hi;
      OP_MFLO: o_alu_result = o_lo;
      default: o_alu_result = i_a + i_b;
    endcase
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vector table for combinational ops plus hand-written MDU sequences
module tb_alu_mdu;
  import alu_pkg::*;
  localparam int W = 32;
`ifdef ALU_MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [4:0] op = OP_ADD;
  logic [W-1:0] a = '0, b = '0, res, hi, lo;
  logic [4:0] shamt = '0;
  logic busy, done;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int checks = 0, failures = 0;
  alu_mdu #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_alu_op(op), .i_a(a), .i_b(b), .i_shamt(shamt),
    .i_start(start), .o_alu_result(res), .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int exp_busy(input logic [4:0] o, input logic [W-1:0] bb);
    logic [W-1:0] m;
    int n;
    n = W;
    m = (o == OP_MULT && bb[W-1]) ? -bb : bb;
    if (EARLY && (o == OP_MULT || o == OP_MULTU)) begin
      n = 1;
      for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    end
    return n + 1;
  endfunction
  task automatic run_mdu(input string name, input logic [4:0] o, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit disturb);
    int nb, dd;
    @(negedge clk);
    op = o; a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; dd = 0;
    while (busy && nb < 200) begin
      nb++;
      if (done) dd++;
      if (disturb && nb == 1) begin
        op = OP_MULTU; a = ~ta; b = 3; start = 1'b1;
      end
      if (disturb && nb == 2) start = 1'b0;
      if (!disturb && nb == 1) begin
        op = OP_MFHI;
        #1 chk({name, " mfhi_while_busy"}, res, m_hi);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, " busy_cycles"}, W'(nb), W'(exp_busy(o, tb)));
    chk({name, " done"}, W'(done), 1);
    chk({name, " done_early"}, W'(dd), 0);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    op = OP_MFLO;
    #1 chk({name, " mflo"}, res, elo);
    @(negedge clk);
    chk({name, " done_drop"}, W'(done), 0);
    m_hi = ehi; m_lo = elo;
  endtask
  typedef struct {
    string      name;
    logic [4:0] op;
    logic [W-1:0] a, b;
    logic [4:0] sh;
    logic [W-1:0] exp;
  } vec_t;
  vec_t v[$];
  initial begin
    v.push_back('{"add",       OP_ADD,  32'd5,          32'd7,          5'd0,  32'd12});
    v.push_back('{"add_wrap",  OP_ADD,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0});
    v.push_back('{"sub",       OP_SUB,  32'd3,          32'd5,          5'd0,  32'hFFFF_FFFE});
    v.push_back('{"and",       OP_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'hF000_F000});
    v.push_back('{"or",        OP_OR,   32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'hFFF0_FFF0});
    v.push_back('{"sll",       OP_SLL,  32'd0,          32'd1,          5'd4,  32'h10});
    v.push_back('{"srl",       OP_SRL,  32'd0,          32'h8000_0000,  5'd31, 32'd1});
    v.push_back('{"sra",       OP_SRA,  32'd0,          32'h8000_0000,  5'd31, 32'hFFFF_FFFF});
    v.push_back('{"slt",       OP_SLT,  32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1});
    v.push_back('{"sltu",      OP_SLTU, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0});
    v.push_back('{"rol",       OP_ROL,  32'h8000_0001,  32'd4,          5'd0,  32'h0000_0018});
    v.push_back('{"rol0",      OP_ROL,  32'h1234_5678,  32'd0,          5'd0,  32'h1234_5678});
    v.push_back('{"rol32",     OP_ROL,  32'h1234_5678,  32'd32,         5'd0,  32'h1234_5678});
    v.push_back('{"fill",      OP_FILL, 32'hFFFF_FF00,  32'd3,          5'd0,  32'hFFFF_FF07});
    v.push_back('{"fill_b0",   OP_FILL, 32'h0000_00F0,  32'd0,          5'd0,  32'h0000_00F0});
    v.push_back('{"fill_big",  OP_FILL, 32'h0000_00F0,  32'd100,        5'd0,  32'hFFFF_FFFF});
    v.push_back('{"fill_gap",  OP_FILL, 32'h0000_0005,  32'd2,          5'd0,  32'h0000_000F});
    v.push_back('{"retired4",  5'b00100, 32'd2,         32'd3,          5'd0,  32'd5});
    v.push_back('{"unused1e",  5'b11110, 32'd10,        32'd20,         5'd0,  32'd30});
    repeat (3) @(negedge clk);
    chk("rst busy", W'(busy), 0);
    chk("rst done", W'(done), 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    op = OP_MFHI;
    #1 chk("rst mfhi", res, 0);
    rst_n = 1'b1;
    foreach (v[i]) begin
      @(negedge clk);
      op = v[i].op; a = v[i].a; b = v[i].b; shamt = v[i].sh;
      #1 chk(v[i].name, res, v[i].exp);
    end
    @(negedge clk);
    op = OP_MTHI; a = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mthi hi", hi, 32'd5);
    chk("mthi busy", W'(busy), 0);
    chk("mthi done", W'(done), 0);
    op = OP_MTLO; a = 32'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo, 32'h55);
    chk("mtlo hi_kept", hi, 32'd5);
    m_hi = 32'd5; m_lo = 32'h55;
    @(negedge clk);
    op = OP_DIV; a = 32'd9; b = 32'd3;
    #1 chk("nonmdu_start busy", W'(busy), 0);
    op = OP_ADD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nonmdu_start busy2", W'(busy), 0);
    run_mdu("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_mdu("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b1);
    run_mdu("mult9x1", OP_MULTU, 32'd9, 32'd1, 32'd0, 32'd9, 1'b0);
    run_mdu("mult_x0", OP_MULT, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0);
    run_mdu("mult_negneg", OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0);
    run_mdu("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_mdu("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_mdu("divu_z", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
    run_mdu("div_z", OP_DIV, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_mdu("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_mdu("divu_dist", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_mdu("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst busy", W'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", W'(busy), 0);
    chk("mid_rst hi", hi, 0);
    chk("mid_rst lo", lo, 0);
    chk("mid_rst done", W'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_mdu("post_rst_mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
